// File: rtl/sweep_pkg.sv
// Shared types and constants for the exhaustive 3-input combinational sweep controller.
package sweep_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } sweep_state_t;

   localparam int NUM_VECS = 8;
   localparam int VEC_W    = 3;
   localparam int ERR_W    = 4;

   localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VECS - 1);
   localparam logic [ERR_W-1:0] ERR_MAX  = ERR_W'(NUM_VECS);

   // Mismatch counter never runs past the number of vectors in a sweep.
   function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] cnt);
      logic [ERR_W-1:0] res;
      if (cnt >= ERR_MAX) begin
         res = ERR_MAX;
      end else begin
         res = cnt + 4'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/comb_golden.sv
// Reference model of the combinational unit under test; y reduces to a&b but is
// written in the same form the unit implements.
module comb_golden
   import sweep_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic c,
   output logic x_exp,
   output logic y_exp
);

   assign x_exp = ~c ^ (a | b);
   assign y_exp = (a | b) & (~(a & b) ^ (a | b));

endmodule

// File: rtl/comb_sweep_ctrl.sv
// Walks a 3-input combinational unit through all eight input vectors, compares its
// x/y results against the golden model and reports mismatch count and first failure.
module comb_sweep_ctrl
   import sweep_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             x_in,
   input  logic             y_in,
   output logic             a,
   output logic             b,
   output logic             c,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [VEC_W-1:0] first_fail
);

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   sweep_state_t     state_r, state_nxt_s;
   logic [VEC_W-1:0] vec_r, vec_nxt_s;
   logic [3:0]       settle_r, settle_nxt_s;
   logic [ERR_W-1:0] err_count_r, err_count_nxt_s;
   logic [VEC_W-1:0] first_fail_r, first_fail_nxt_s;
   logic             pass_r, pass_nxt_s;
   logic [VEC_W-1:0] abc_r, abc_nxt_s;
   logic             busy_r, busy_nxt_s;
   logic             done_r, done_nxt_s;
   logic             x_exp_s, y_exp_s, mismatch_s;

   comb_golden u_golden (
      .a     (vec_r[2]),
      .b     (vec_r[1]),
      .c     (vec_r[0]),
      .x_exp (x_exp_s),
      .y_exp (y_exp_s)
   );

   assign mismatch_s = (x_in != x_exp_s) || (y_in != y_exp_s);

   // Next-state and datapath update logic.
   always_comb begin
      state_nxt_s      = state_r;
      vec_nxt_s        = vec_r;
      settle_nxt_s     = settle_r;
      err_count_nxt_s  = err_count_r;
      first_fail_nxt_s = first_fail_r;
      pass_nxt_s       = pass_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_nxt_s      = ST_DRIVE;
               vec_nxt_s        = 3'd0;
               settle_nxt_s     = 4'd0;
               err_count_nxt_s  = 4'd0;
               first_fail_nxt_s = 3'd0;
               pass_nxt_s       = 1'b0;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_DRIVE: begin
            if (settle_r >= SETTLE_LAST) begin
               state_nxt_s = ST_CHECK;
            end else begin
               settle_nxt_s = settle_r + 4'd1;
            end
         end
         ST_CHECK: begin
            if (mismatch_s) begin
               err_count_nxt_s = err_sat_inc(err_count_r);
               if (err_count_r == 4'd0) begin
                  first_fail_nxt_s = vec_r;
               end else begin
                  first_fail_nxt_s = first_fail_r;
               end
            end else begin
               err_count_nxt_s = err_count_r;
            end
            if (vec_r == LAST_VEC) begin
               state_nxt_s = ST_DONE;
               // Final verdict has to include the vector being checked right now.
               pass_nxt_s  = (err_count_r == 4'd0) && !mismatch_s;
            end else begin
               state_nxt_s  = ST_DRIVE;
               vec_nxt_s    = vec_r + 3'd1;
               settle_nxt_s = 4'd0;
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Output decode from the upcoming state so the outputs can be registered.
   always_comb begin
      busy_nxt_s = 1'b0;
      done_nxt_s = 1'b0;
      abc_nxt_s  = 3'd0;
      case (state_nxt_s)
         ST_DRIVE, ST_CHECK: begin
            busy_nxt_s = 1'b1;
            abc_nxt_s  = vec_nxt_s;
         end
         ST_DONE: begin
            done_nxt_s = 1'b1;
         end
         default: begin
            busy_nxt_s = 1'b0;
         end
      endcase
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         vec_r        <= 3'd0;
         settle_r     <= 4'd0;
         err_count_r  <= 4'd0;
         first_fail_r <= 3'd0;
         pass_r       <= 1'b0;
         abc_r        <= 3'd0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         vec_r        <= vec_nxt_s;
         settle_r     <= settle_nxt_s;
         err_count_r  <= err_count_nxt_s;
         first_fail_r <= first_fail_nxt_s;
         pass_r       <= pass_nxt_s;
         abc_r        <= abc_nxt_s;
         busy_r       <= busy_nxt_s;
         done_r       <= done_nxt_s;
      end
   end

   assign a          = abc_r[2];
   assign b          = abc_r[1];
   assign c          = abc_r[0];
   assign busy       = busy_r;
   assign done       = done_r;
   assign pass       = pass_r;
   assign err_count  = err_count_r;
   assign first_fail = first_fail_r;

endmodule

// File: tb/tb_comb_sweep_ctrl.sv
// Directed bench for comb_sweep_ctrl: default-settle instance with a faultable unit
// model, plus a SETTLE_CYCLES=3 instance with a correct model.
module tb_comb_sweep_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start1, start3;
   logic [1:0] mode;
   logic       sel;
   int         n_checks = 0;
   int         n_pass   = 0;

   // Hand-derived truth tables, bit index = {a,b,c}.
   logic [7:0] x_tbl = 8'b1010_1001;
   logic [7:0] y_tbl = 8'b1100_0000;

   logic       a1, b1, c1, busy1, done1, pass1, x1, y1;
   logic [3:0] err1;
   logic [2:0] ff1;
   logic       a3, b3, c3, busy3, done3, pass3, x3, y3;
   logic [3:0] err3;
   logic [2:0] ff3;

   always #5 clk = ~clk;

   assign x1 = (mode == 2'd1) ? 1'b0 : x_tbl[{a1, b1, c1}];
   assign y1 = (mode == 2'd2) ? 1'b0 : y_tbl[{a1, b1, c1}];
   assign x3 = x_tbl[{a3, b3, c3}];
   assign y3 = y_tbl[{a3, b3, c3}];

   comb_sweep_ctrl dut1 (
      .clk(clk), .rst(rst), .start(start1), .x_in(x1), .y_in(y1),
      .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
      .err_count(err1), .first_fail(ff1)
   );

   comb_sweep_ctrl #(.SETTLE_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .x_in(x3), .y_in(y3),
      .a(a3), .b(b3), .c(c3), .busy(busy3), .done(done3), .pass(pass3),
      .err_count(err3), .first_fail(ff3)
   );

   logic [2:0] cur_abc;
   logic       cur_busy, cur_done;
   assign cur_abc  = sel ? {a3, b3, c3} : {a1, b1, c1};
   assign cur_busy = sel ? busy3 : busy1;
   assign cur_done = sel ? done3 : done1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_start(input logic v);
      if (sel) start3 = v;
      else     start1 = v;
   endtask

   // One start pulse, then watch 60 cycles; cycle 1 is the cycle after start is sampled.
   task automatic run_sweep(input int settle, input int restart_at,
                            output int done_at, output int n_done,
                            output int abc_bad, output int busy_bad);
      int per;
      logic [2:0] exp_abc;
      per = settle + 1;
      done_at = -1; n_done = 0; abc_bad = 0; busy_bad = 0;
      @(negedge clk); set_start(1'b1);
      @(posedge clk); #1; set_start(1'b0);
      for (int k = 1; k <= 60; k++) begin
         if (k > 1) begin
            @(posedge clk); #1;
         end
         exp_abc = (k <= 8 * per) ? 3'((k - 1) / per) : 3'd0;
         if (cur_abc != exp_abc) abc_bad++;
         if (cur_busy != (k <= 8 * per)) busy_bad++;
         if (cur_done) begin
            n_done++;
            if (done_at < 0) done_at = k;
         end
         set_start(k == restart_at);
      end
   endtask

   initial begin
      int done_at, n_done, abc_bad, busy_bad, k;
      rst = 1'b1; start1 = 1'b0; start3 = 1'b0; mode = 2'd0; sel = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_abc", {a1, b1, c1}, 0);
      check_val("rst_busy", busy1, 0);
      check_val("rst_done", done1, 0);
      check_val("rst_pass", pass1, 0);
      check_val("rst_err", err1, 0);
      check_val("rst_ff", ff1, 0);
      @(negedge clk); rst = 1'b0;

      // Correct unit
      run_sweep(1, 0, done_at, n_done, abc_bad, busy_bad);
      check_val("ok_done_at", done_at, 17);
      check_val("ok_n_done", n_done, 1);
      check_val("ok_abc_seq", abc_bad, 0);
      check_val("ok_busy_seq", busy_bad, 0);
      check_val("ok_pass", pass1, 1);
      check_val("ok_err", err1, 0);
      check_val("ok_ff", ff1, 0);

      // x stuck at 0
      mode = 2'd1;
      run_sweep(1, 0, done_at, n_done, abc_bad, busy_bad);
      check_val("xs0_done_at", done_at, 17);
      check_val("xs0_err", err1, 4);
      check_val("xs0_ff", ff1, 0);
      check_val("xs0_pass", pass1, 0);

      // y stuck at 0
      mode = 2'd2;
      run_sweep(1, 0, done_at, n_done, abc_bad, busy_bad);
      check_val("ys0_err", err1, 2);
      check_val("ys0_ff", ff1, 6);
      check_val("ys0_pass", pass1, 0);

      // start re-pulsed mid-sweep is ignored
      mode = 2'd0;
      run_sweep(1, 5, done_at, n_done, abc_bad, busy_bad);
      check_val("restart_n_done", n_done, 1);
      check_val("restart_done_at", done_at, 17);
      check_val("restart_pass", pass1, 1);
      check_val("restart_err", err1, 0);

      // Reset while vec=3 aborts the sweep
      @(negedge clk); start1 = 1'b1;
      @(posedge clk); #1; start1 = 1'b0;
      k = 0;
      while ({a1, b1, c1} != 3'd3 && k < 20) begin
         @(posedge clk); #1; k++;
      end
      check_val("reach_vec3", {a1, b1, c1}, 3);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      check_val("abort_abc", {a1, b1, c1}, 0);
      check_val("abort_busy", busy1, 0);
      check_val("abort_done", done1, 0);
      check_val("abort_pass", pass1, 0);
      check_val("abort_err", err1, 0);
      @(negedge clk); rst = 1'b0;
      n_done = 0; busy_bad = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done1) n_done++;
         if (busy1) busy_bad++;
      end
      check_val("abort_no_done", n_done, 0);
      check_val("abort_idle", busy_bad, 0);
      run_sweep(1, 0, done_at, n_done, abc_bad, busy_bad);
      check_val("post_abort_done_at", done_at, 17);
      check_val("post_abort_abc_seq", abc_bad, 0);
      check_val("post_abort_pass", pass1, 1);

      // rst wins over start on the same edge
      @(negedge clk); rst = 1'b1; start1 = 1'b1;
      @(posedge clk); #1;
      check_val("rst_prio_busy", busy1, 0);
      @(negedge clk); rst = 1'b0; start1 = 1'b0;
      @(posedge clk); #1;
      check_val("rst_prio_idle", busy1, 0);

      // start held high: one IDLE cycle after DONE, then a new sweep
      @(negedge clk); start1 = 1'b1;
      k = 0;
      while (!done1 && k < 40) begin
         @(posedge clk); #1; k++;
      end
      check_val("held_done_seen", done1, 1);
      @(posedge clk); #1;
      check_val("held_idle_gap", busy1, 0);
      @(posedge clk); #1;
      check_val("held_restart", busy1, 1);
      @(negedge clk); start1 = 1'b0;
      repeat (25) @(posedge clk);

      // SETTLE_CYCLES=3 instance
      sel = 1'b1;
      run_sweep(3, 0, done_at, n_done, abc_bad, busy_bad);
      check_val("s3_done_at", done_at, 33);
      check_val("s3_n_done", n_done, 1);
      check_val("s3_abc_seq", abc_bad, 0);
      check_val("s3_busy_seq", busy_bad, 0);
      check_val("s3_pass", pass3, 1);
      check_val("s3_err", err3, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
